freq_meter: RTL and testbench

Gated frequency counter that measures an external digital signal against the system clock. It is the consumer side of the clock-divider path: divided clock taps, or any off-board square wave, enter on `sig_in`. Rising edges are counted over a fixed window of system-clock cycles, and each result is published with a one-cycle valid strobe. It sits beside the divider in the lab designs for self-check and for display of measured rates.

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/freq_meter_edge_sync.sv | 23 ++
 rtl/freq_meter.sv | 116 +++++++++++
 tb/tb_freq_meter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the gated frequency counter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_GATE_CYCLES = 50_000_000;
    localparam int DEFAULT_CNT_W       = 32;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer followed by a delay flop; edge_p is a one-cycle pulse per rising edge of d.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic edge_p
);

    logic [1:0] sync_reg;
    logic       dly_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b00;
            dly_reg  <= 1'b0;
        end else begin
            {dly_reg, sync_reg} <= {sync_reg, d};
        end
    end

    assign edge_p = sync_reg[1] & ~dly_reg;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over GATE_CYCLES clocks.
// Define FREQ_METER_AUTO_EN to re-arm the window automatically after every result.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             overflow
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic edge_p;

    edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (sig_in),
        .edge_p (edge_p)
    );

    state_t            state_reg,    state_next;
    logic [GATE_W-1:0] gate_cnt_reg, gate_cnt_next;
    logic [CNT_W-1:0]  edge_cnt_reg, edge_cnt_next;
    logic              ovf_reg,      ovf_next;
    logic [CNT_W-1:0]  count_reg,    count_next;
    logic              overflow_reg, overflow_next;
    logic              valid_reg,    valid_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gate_cnt_reg <= gate_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            ovf_reg      <= ovf_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            valid_reg    <= valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gate_cnt_next = gate_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        ovf_next      = ovf_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        valid_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = GATE;
                    gate_cnt_next = '0;
                    edge_cnt_next = '0;
                    ovf_next      = 1'b0;
                end
            end
            GATE: begin
                gate_cnt_next = gate_cnt_reg + 1'b1;
                // Saturate rather than wrap so a too-fast input reads as full scale.
                if (edge_p) begin
                    if (edge_cnt_reg == {CNT_W{1'b1}}) begin
                        ovf_next = 1'b1;
                    end else begin
                        edge_cnt_next = edge_cnt_reg + 1'b1;
                    end
                end
                // The last gate cycle's edge is folded into the published result.
                if (gate_cnt_reg == GATE_LAST) begin
                    state_next    = DONE;
                    count_next    = edge_cnt_next;
                    overflow_next = ovf_next;
                    valid_next    = 1'b1;
                end
            end
            DONE: begin
`ifdef FREQ_METER_AUTO_EN
                state_next    = GATE;
                gate_cnt_next = '0;
                edge_cnt_next = '0;
                ovf_next      = 1'b0;
`else
                state_next    = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign count    = count_reg;
    assign valid    = valid_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: table-driven windows, corner sequences and
// randomized periods checked against an edge-timeline reference model.
module tb_freq_meter;

    localparam int G    = 100;
    localparam int MAXC = 16384;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        sig_in = 1'b0;
    logic        start  = 1'b0;
    logic        busy,  valid,  overflow;
    logic [31:0] count32;
    logic        busy4, valid4, overflow4;
    logic [3:0]  count4;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .busy(busy), .count(count32), .valid(valid), .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
        .busy(busy4), .count(count4), .valid(valid4), .overflow(overflow4)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Timeline of sig_in as seen at each clock edge (forced low while in reset).
    int cyc = 0;
    bit samp [MAXC];
    int gen_period = 0;
    bit gen_level  = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < MAXC) samp[cyc] = rst ? 1'b0 : sig_in;
    end

    always @(negedge clk) begin
        if (gen_period == 0) sig_in = gen_level;
        else                 sig_in = ((cyc % gen_period) < (gen_period / 2));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Rising edges sampled at edges n-1 .. n+G-2 land in the window whose start was sampled at edge n.
    function automatic int model_edges(input int n);
        int c = 0;
        for (int a = n - 1; a <= n + G - 2; a++) begin
            if (a >= 1 && a < MAXC && samp[a] && !samp[a-1]) c++;
        end
        return c;
    endfunction

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    task automatic run_window(input string tag, input bit extra, input int abort_off, input int step_off,
                              output int n, output int nvalid, output int vedge,
                              output logic [31:0] c32, output logic o32,
                              output logic [3:0] c4, output logic o4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = cyc;
        nvalid = 0;
        vedge = -1;
        c32 = '0; o32 = 1'b0; c4 = '0; o4 = 1'b0;
        check({tag, ".busy_rise"}, busy, 1);
        for (int i = 0; i < G + 20; i++) begin
            start = extra && (cyc == n + 9 || cyc == n + 99 || cyc == n + G);
            rst   = (abort_off > 0) && (cyc == n + abort_off - 1);
            if (step_off > 0 && cyc == n + step_off) gen_level = 1'b1;
            @(negedge clk);
            if (valid) begin
                nvalid++;
                vedge = cyc;
                c32 = count32;
                o32 = overflow;
            end
            if (valid4) begin
                c4 = count4;
                o4 = overflow4;
            end
            if (abort_off > 0 && cyc == n + abort_off) begin
                check({tag, ".abort_busy"},  busy,     0);
                check({tag, ".abort_count"}, count32,  0);
                check({tag, ".abort_valid"}, valid,    0);
                check({tag, ".abort_ovf"},   overflow, 0);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        if (nvalid == 0) begin
            c32 = count32; o32 = overflow; c4 = count4; o4 = overflow4;
        end
        check({tag, ".busy_fall"}, busy, 0);
    endtask

    typedef struct {
        string name;
        int    period;
        bit    level;
        int    exp32;
        int    exp4;
        bit    ovf4;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          n, nvalid, vedge, exp;
        logic [31:0] c32;
        logic        o32, o4;
        logic [3:0]  c4;

        tbl[0] = '{"period10", 10, 1'b0, 10, 10, 1'b0};
        tbl[1] = '{"hold0",     0, 1'b0,  0,  0, 1'b0};
        tbl[2] = '{"hold1",     0, 1'b1,  0,  0, 1'b0};
        tbl[3] = '{"period4",   4, 1'b0, 25, 15, 1'b1};
        tbl[4] = '{"period20", 20, 1'b0,  5,  5, 1'b0};
        tbl[5] = '{"period2",   2, 1'b0, 50, 15, 1'b1};

        rst = 1'b1;
        idle(4);
        check("reset.busy",  busy,     0);
        check("reset.count", count32,  0);
        check("reset.valid", valid,    0);
        check("reset.ovf",   overflow, 0);
        check("reset.busy4", busy4,    0);
        check("reset.count4", count4,  0);
        rst = 1'b0;
        idle(3);

`ifdef FREQ_METER_AUTO_EN
        begin
            int busy_low = 0;
            int early    = 0;
            gen_period = 10;
            idle(5);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = cyc;
            for (int k = 0; k < 3; k++) begin
                int ve = n + G + k * (G + 1);
                for (int t = 0; t < G + 10 && cyc < ve; t++) begin
                    @(negedge clk);
                    if (!busy) busy_low++;
                    if (valid && cyc != ve) early++;
                end
                exp = model_edges(n + k * (G + 1));
                check($sformatf("auto%0d.cycle", k),  cyc,     ve);
                check($sformatf("auto%0d.valid", k),  valid,   1);
                check($sformatf("auto%0d.count", k),  count32, exp);
                check($sformatf("auto%0d.table", k),  count32, 10);
                check($sformatf("auto%0d.count4", k), count4,  (exp > 15) ? 15 : exp);
            end
            check("auto.busy_low_cycles", busy_low, 0);
            check("auto.extra_valids",    early,    0);
            rst = 1'b1;
            idle(2);
            rst = 1'b0;
        end
`else
        foreach (tbl[i]) begin
            gen_period = tbl[i].period;
            gen_level  = tbl[i].level;
            idle(5);
            run_window(tbl[i].name, 1'b0, 0, 0, n, nvalid, vedge, c32, o32, c4, o4);
            check({tbl[i].name, ".nvalid"}, nvalid, 1);
            check({tbl[i].name, ".latency"}, vedge - n, G);
            check({tbl[i].name, ".count"},  c32, tbl[i].exp32);
            check({tbl[i].name, ".ovf"},    o32, 0);
            check({tbl[i].name, ".count4"}, c4,  tbl[i].exp4);
            check({tbl[i].name, ".ovf4"},   o4,  tbl[i].ovf4);
        end

        // Single 0->1 step in the middle of the window.
        gen_period = 0;
        gen_level  = 1'b0;
        idle(5);
        run_window("step", 1'b0, 0, 50, n, nvalid, vedge, c32, o32, c4, o4);
        check("step.nvalid", nvalid, 1);
        check("step.count",  c32,    1);
        check("step.count4", c4,     1);
        gen_level = 1'b0;

        // Extra starts during GATE and DONE are ignored.
        gen_period = 10;
        idle(5);
        run_window("restart", 1'b1, 0, 0, n, nvalid, vedge, c32, o32, c4, o4);
        check("restart.nvalid",  nvalid,    1);
        check("restart.latency", vedge - n, G);
        check("restart.count",   c32,       10);

        // Reset at gate cycle 50 aborts; a fresh start still measures correctly.
        run_window("abort", 1'b0, 50, 0, n, nvalid, vedge, c32, o32, c4, o4);
        check("abort.nvalid", nvalid, 0);
        check("abort.count",  c32,    0);
        idle(3);
        run_window("after_abort", 1'b0, 0, 0, n, nvalid, vedge, c32, o32, c4, o4);
        check("after_abort.nvalid", nvalid, 1);
        check("after_abort.count",  c32,    10);

        // Randomized periods and phases against the reference model.
        for (int r = 0; r < 8; r++) begin
            string tag;
            tag = $sformatf("rand%0d", r);
            gen_period = $urandom_range(2, 40);
            idle($urandom_range(3, 12));
            run_window(tag, 1'b0, 0, 0, n, nvalid, vedge, c32, o32, c4, o4);
            exp = model_edges(n);
            check({tag, ".nvalid"}, nvalid, 1);
            check({tag, ".count"},  c32,    exp);
            check({tag, ".count4"}, c4,     (exp > 15) ? 15 : exp);
            check({tag, ".ovf4"},   o4,     (exp > 15) ? 1 : 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
